// File: rtl/sdram_pattern_tester.sv
// Write/read-back pattern tester driving the sdram_controller request port and reporting status.
// Define SDRAM_TEST_LFSR_EN to take the pattern from a 32-bit Galois LFSR instead of the address.
module sdram_pattern_tester #(
  parameter int                ADDR_W      = 27,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 27'h0000020,
  parameter int                ADDR_STRIDE = 2,
  parameter int                NUM_WORDS   = 16,
  parameter logic [31:0]       PATTERN     = 32'h55AA_33CC,
  parameter logic [31:0]       SEED        = 32'hACE1_0001,
  parameter int                TIMEOUT     = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_init_done,
  input  logic              i_busy,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_rwn,
  output logic              o_adv,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int              TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]     K_LAST    = 16'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WR_REQ    = 3'd2,
    S_WR_WAIT   = 3'd3,
    S_RD_REQ    = 3'd4,
    S_RD_WAIT   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [15:0]         r_k;
  logic [TW-1:0]       r_tcnt;
  logic                r_adv;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rwn;
  logic                r_running;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [15:0]         r_err_count;
  logic [ADDR_W-1:0]   r_first_err_addr;

  logic                w_in_wait;
  logic                w_ack_ok;
  logic                w_adv_go;
  logic                w_last;
  logic                w_tmo;
  logic                w_mismatch;
  logic                w_start;
  logic                w_init_go;
  logic                w_to_done;
  logic [DATA_W-1:0]   w_pat;
  logic [ADDR_W-1:0]   w_addr_k;

  assign w_addr_k = BASE_ADDR + ADDR_W'(r_k) * ADDR_W'(ADDR_STRIDE);

`ifdef SDRAM_TEST_LFSR_EN
  localparam logic [31:0] LFSR_SEED = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  logic [31:0] r_lfsr;

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Reload at the start of each phase so reads regenerate the written sequence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= 32'h0000_0000;
    end else if (w_init_go || (r_state == S_WR_WAIT && w_ack_ok && w_last)) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_ack_ok) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign w_pat = r_lfsr;
`else
  assign w_pat = PATTERN ^ {~r_k, r_k};
`endif

  // Handshake decode; an ack coincident with adv belongs to no request yet.
  always_comb begin
    w_in_wait  = (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
    w_ack_ok   = w_in_wait && i_ack && !r_adv;
    w_adv_go   = ((r_state == S_WR_REQ) || (r_state == S_RD_REQ)) && !i_busy;
    w_last     = (r_k == K_LAST);
    w_tmo      = w_in_wait && !w_ack_ok && (r_tcnt == TCNT_LAST);
    w_mismatch = (r_state == S_RD_WAIT) && w_ack_ok && (i_rdata != w_pat);
    w_start    = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    w_init_go  = (r_state == S_WAIT_INIT) && i_init_done;
    w_to_done  = ((r_state == S_RD_WAIT) && w_ack_ok && w_last) || w_tmo;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_start) w_next = S_WAIT_INIT; else w_next = S_IDLE;
      S_WAIT_INIT: if (i_init_done) w_next = S_WR_REQ; else w_next = S_WAIT_INIT;
      S_WR_REQ:    if (w_adv_go) w_next = S_WR_WAIT; else w_next = S_WR_REQ;
      S_WR_WAIT: begin
        if (w_ack_ok)   w_next = w_last ? S_RD_REQ : S_WR_REQ;
        else if (w_tmo) w_next = S_DONE;
        else            w_next = S_WR_WAIT;
      end
      S_RD_REQ:    if (w_adv_go) w_next = S_RD_WAIT; else w_next = S_RD_REQ;
      S_RD_WAIT: begin
        if (w_ack_ok)   w_next = w_last ? S_DONE : S_RD_REQ;
        else if (w_tmo) w_next = S_DONE;
        else            w_next = S_RD_WAIT;
      end
      S_DONE:      if (w_start) w_next = S_WAIT_INIT; else w_next = S_DONE;
      default:     w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Request, timer and status registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k              <= 16'h0;
      r_tcnt           <= '0;
      r_adv            <= 1'b0;
      r_addr           <= '0;
      r_wdata          <= '0;
      r_rwn            <= 1'b1;
      r_running        <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_timeout        <= 1'b0;
      r_err_count      <= 16'h0;
      r_first_err_addr <= '0;
    end else begin
      r_adv <= w_adv_go;
      if (w_adv_go) begin
        r_addr <= w_addr_k;
        r_rwn  <= (r_state == S_RD_REQ);
        r_tcnt <= '0;
        if (r_state == S_WR_REQ) r_wdata <= w_pat;
      end else if (w_in_wait) begin
        r_tcnt <= r_tcnt + TW'(1);
      end

      if (w_init_go)     r_k <= 16'h0;
      else if (w_ack_ok) r_k <= w_last ? 16'h0 : r_k + 16'd1;

      if (w_start) begin
        r_running        <= 1'b1;
        r_done           <= 1'b0;
        r_pass           <= 1'b0;
        r_timeout        <= 1'b0;
        r_err_count      <= 16'h0;
        r_first_err_addr <= '0;
      end

      if (w_mismatch) begin
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        if (r_err_count == 16'h0)    r_first_err_addr <= r_addr;
      end

      if (w_to_done) begin
        r_running <= 1'b0;
        r_done    <= 1'b1;
        r_pass    <= !w_tmo && !w_mismatch && (r_err_count == 16'h0);
        if (w_tmo) r_timeout <= 1'b1;
      end
    end
  end

  assign o_addr           = r_addr;
  assign o_wdata          = r_wdata;
  assign o_rwn            = r_rwn;
  assign o_adv            = r_adv;
  assign o_running        = r_running;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_timeout        = r_timeout;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a controller model with a request scoreboard plus table-driven passes.
module tb_sdram_pattern_tester;
  localparam int NW  = 4;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n, i_start, i_init_done, i_busy, i_ack;
  logic [31:0] i_rdata;
  logic [26:0] o_addr, o_first_err_addr;
  logic [31:0] o_wdata;
  logic        o_rwn, o_adv, o_running, o_done, o_pass, o_timeout;
  logic [15:0] o_err_count;

  always #5 clk = ~clk;

  sdram_pattern_tester #(.NUM_WORDS(NW), .SEED(32'h0), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_init_done(i_init_done),
    .i_busy(i_busy), .i_ack(i_ack), .i_rdata(i_rdata), .o_addr(o_addr), .o_wdata(o_wdata),
    .o_rwn(o_rwn), .o_adv(o_adv), .o_running(o_running), .o_done(o_done), .o_pass(o_pass),
    .o_timeout(o_timeout), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr)
  );

  typedef struct { logic rwn; logic [26:0] addr; logic [31:0] data; } req_t;
  typedef struct { int corrupt_k; int lat; logic exp_pass; logic [15:0] exp_err; logic [26:0] exp_first; } vec_t;

  req_t sb_q[$];
  vec_t vecs[4];
  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, adv_count = 0, last_adv_cyc = 0;
  int   lat = 3, cnt = 0;
  logic pend = 1'b0, prev_adv = 1'b0, p_rd = 1'b0;
  logic [26:0] p_addr = 27'h0;
  logic corr_en = 1'b0, drop_en = 1'b0;
  logic [26:0] corr_addr = 27'h0, drop_addr = 27'h0;
  logic [31:0] mem [logic [26:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_pat(input int k);
`ifdef SDRAM_TEST_LFSR_EN
    logic [31:0] s = 32'h1;
    for (int i = 0; i < k; i++) s = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    return s;
`else
    logic [15:0] kk = 16'(k);
    return 32'h55AA_33CC ^ {~kk, kk};
`endif
  endfunction

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Controller model: checks each request against the scoreboard and acks it lat cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      i_ack = 1'b0; i_rdata = 32'h0; pend = 1'b0; prev_adv = 1'b0;
    end else begin
      i_ack = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          i_ack   = 1'b1;
          i_rdata = p_rd ? (mem[p_addr] ^ ((corr_en && p_addr == corr_addr) ? 32'h1 : 32'h0)) : 32'h0;
          pend    = 1'b0;
        end else cnt--;
      end
      if (o_adv) begin
        req_t e;
        adv_count++;
        last_adv_cyc = cyc;
        chk("adv_width", prev_adv, 1'b0);
        chk("sb_pending", 64'(sb_q.size() > 0), 1'b1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("req_rwn", o_rwn, e.rwn);
          chk("req_addr", o_addr, e.addr);
          if (!e.rwn) chk("req_wdata", o_wdata, e.data);
        end
        if (!o_rwn) mem[o_addr] = o_wdata;
        if (!(drop_en && !o_rwn && o_addr == drop_addr)) begin
          pend = 1'b1; cnt = lat; p_addr = o_addr; p_rd = o_rwn;
        end
      end
      prev_adv = o_adv;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push_pass(input int nw, input int nr);
    for (int k = 0; k < nw; k++) sb_q.push_back('{1'b0, 27'(27'h20 + 2 * k), exp_pat(k)});
    for (int k = 0; k < nr; k++) sb_q.push_back('{1'b1, 27'(27'h20 + 2 * k), exp_pat(k)});
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick();
    i_start = 1'b0; tick();
  endtask

  task automatic wait_done(input int budget, output int c);
    for (int i = 0; i < budget; i++) begin
      if (o_done) break;
      tick();
    end
    chk("done_in_time", o_done, 1'b1);
    c = cyc;
  endtask

  task automatic wait_adv(input int a0, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (adv_count != a0) break;
      tick();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_adv"}, o_adv, 1'b0);       chk({tag, "_rwn"}, o_rwn, 1'b1);
    chk({tag, "_running"}, o_running, 1'b0); chk({tag, "_done"}, o_done, 1'b0);
    chk({tag, "_pass"}, o_pass, 1'b0);     chk({tag, "_timeout"}, o_timeout, 1'b0);
    chk({tag, "_err"}, o_err_count, 16'h0); chk({tag, "_first"}, o_first_err_addr, 27'h0);
    chk({tag, "_addr"}, o_addr, 27'h0);    chk({tag, "_wdata"}, o_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, c0, a0;
    rst_n = 1'b0; i_start = 1'b0; i_init_done = 1'b1; i_busy = 1'b0;
    vecs[0] = '{-1, 3, 1'b1, 16'd0, 27'h0};
    vecs[1] = '{ 2, 3, 1'b0, 16'd1, 27'h24};
    vecs[2] = '{ 0, 1, 1'b0, 16'd1, 27'h20};
    vecs[3] = '{ 3, 5, 1'b0, 16'd1, 27'h26};
    chk("pat_k0", exp_pat(0), 32'hAA55_33CC);

    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1; tick();

    for (int v = 0; v < 4; v++) begin
      lat       = vecs[v].lat;
      corr_en   = (vecs[v].corrupt_k >= 0);
      corr_addr = 27'(27'h20 + 2 * vecs[v].corrupt_k);
      push_pass(NW, NW);
      pulse_start();
      chk("clr_running", o_running, 1'b1);
      chk("clr_done", o_done, 1'b0);
      chk("clr_err", o_err_count, 16'h0);
      wait_done(400, c);
      chk("pass", o_pass, vecs[v].exp_pass);
      chk("err_count", o_err_count, vecs[v].exp_err);
      chk("first_err", o_first_err_addr, vecs[v].exp_first);
      chk("no_timeout", o_timeout, 1'b0);
      chk("idle_running", o_running, 1'b0);
      chk("sb_drained", sb_q.size(), 0);
    end
    corr_en = 1'b0; lat = 3;

    // Late init: nothing issued until init_done, then first adv two cycles later.
    i_init_done = 1'b0;
    push_pass(NW, NW);
    pulse_start();
    a0 = adv_count;
    repeat (500) tick();
    chk("init_hold_adv", adv_count, a0);
    i_init_done = 1'b1; c0 = cyc;
    wait_adv(a0, 20);
    chk("init_first_adv_cyc", last_adv_cyc, c0 + 2);
    i_init_done = 1'b0;
    wait_done(400, c);
    i_init_done = 1'b1;
    chk("init_pass", o_pass, 1'b1);

    // Second write never acked.
    drop_en = 1'b1; drop_addr = 27'h22;
    push_pass(2, 0);
    pulse_start();
    wait_done(2000, c);
    chk("tmo_flag", o_timeout, 1'b1);
    chk("tmo_pass", o_pass, 1'b0);
    chk("tmo_cycles", c - last_adv_cyc, TMO);
    a0 = adv_count;
    repeat (20) tick();
    chk("tmo_no_adv", adv_count, a0);
    chk("tmo_sb", sb_q.size(), 0);
    drop_en = 1'b0;

    // Busy held at the first request, then async reset during a read adv.
    i_busy = 1'b1;
    push_pass(NW, NW);
    pulse_start();
    a0 = adv_count;
    repeat (10) tick();
    chk("busy_hold_adv", adv_count, a0);
    i_busy = 1'b0; c0 = cyc;
    wait_adv(a0, 20);
    chk("busy_adv_cyc", last_adv_cyc, c0 + 1);
    for (int i = 0; i < 300; i++) begin
      if (o_adv && o_rwn) break;
      tick();
    end
    chk("rd_adv_seen", o_adv && o_rwn, 1'b1);
    rst_n = 1'b0; #1;
    chk_reset("async");
    sb_q.delete();
    tick(); tick();
    rst_n = 1'b1; tick();
    chk("post_rst_running", o_running, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
